icache_dm_refill: RTL and testbench
===================================

Name: icache_dm_refill

Overview:
- Parametrised direct-mapped instruction cache with its own miss/refill state machine.
- Sits between the multicycle MIPS fetch stage and instruction memory.
- Replaces the fixed 128-bit-line lookup-only cache.
- Adds a memory request/acknowledge handshake, valid bits, a flush operation and saturating hit/miss counters.

Parameters:
- ADDR_W, 32, byte-address width.
- WORD_W, 32, instruction width. Fixed at 32 for byte-offset math; other values are illegal.
- WORDS_PER_LINE, 4, words per line. Power of two, ≥2.
- NUM_LINES, 16, number of lines. Power of two, ≥2.
- CNT_W, 16, width of the hit/miss counters.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  ADDR_W  fetch byte address. Bits [1:0] are ignored.
- hit  out  1  cpu_instr valid this cycle for cpu_addr.
- cpu_instr  out  WORD_W  fetched instruction.
- busy  out  1  refill or flush in progress.
- mem_req  out  1  line refill request.
- mem_addr  out  ADDR_W  line-aligned refill address.
- mem_ack  in  1  mem_line valid, refill complete.
- mem_line  in  WORDS_PER_LINE*WORD_W  refill data. Word 0 is in bits [WORD_W-1:0].
- flush  in  1  invalidate all lines.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE)+2 and IDX = log2(NUM_LINES).
  - word = cpu_addr[OFF-1:2]
  - index = cpu_addr[OFF+IDX-1:OFF]
  - tag = cpu_addr[ADDR_W-1:OFF+IDX]
- Storage: data array, tag array, valid bit per line. Only valid bits and counters are reset.
- Reset (async, reset_n=0):
  - All valid bits cleared, FSM to IDLE, counters cleared.
  - Outputs: hit=0, mem_req=0, mem_addr=0, busy=0, cpu_instr=0.
- Reset mid-refill abandons the refill. mem_req drops immediately.
- FSM states are IDLE, REFILL and FLUSH.
- IDLE:
  - hit is combinational: cpu_req & valid[index] & (tag match). cpu_instr is the selected word, zero-latency.
  - On a hit, hit_count increments at the clock edge.
  - On cpu_req & miss (no flush): miss_count increments and the FSM goes to REFILL. mem_addr latches {tag,index,OFF zero bits}.
  - flush has priority over a miss in the same cycle: go to FLUSH, and miss_count does not increment.
- REFILL:
  - mem_req=1 and busy=1. mem_addr is held stable until mem_ack.
  - hit=0 and cpu_req is ignored. The CPU must hold cpu_addr stable.
  - On mem_ack: write mem_line to data[index], write tag, set valid, go to IDLE.
  - The held request hits the next cycle (miss latency = mem_ack cycle + 1).
  - mem_ack outside REFILL is ignored.
- Flush during REFILL:
  - Latched as flush_pend.
  - On mem_ack, the line is written with valid cleared and the FSM goes to FLUSH. The re-presented fetch then misses again.
- FLUSH:
  - One cycle. Clears all valid bits, busy=1, hit=0. Then go to IDLE.
- Counters saturate at all-ones and never wrap.
- Two hits on the same line in consecutive cycles each count.
- Index/tag collisions: a refill overwrites the previous line unconditionally (direct-mapped).

Test Plan:
- Reset, then cpu_req with cpu_addr=0x84 → hit=0. Next cycle mem_req=1, mem_addr=0x80, busy=1, miss_count=1. mem_ack after 3 cycles with mem_line={D3,D2,D1,D0} → the following cycle hit=1, cpu_instr=D1. hit_count then increments.
- After the line at 0x80 is filled, fetch 0x80, 0x88, 0x8C on consecutive cycles → hit=1 each cycle, instr D0, D2, D3, hit_count +3, no mem_req.
- Fetch 0x1AC (index 0xA, tag 1) → refill mem_addr=0x1A0, word 3 returned. Then fetch 0xAC (same index, tag 0) → miss, refill overwrites line 0xA. A re-fetch of 0x1AC then misses again.
- Assert flush while mem_req is pending. Give mem_ack next cycle → one FLUSH cycle with busy=1. Then 0x84 misses again (mem_req=1), including the just-refilled line.
- Drop reset_n mid-refill → mem_req=0 and busy=0 immediately, counters=0. After release, a previously filled address misses.
- Force hit_count to saturation (CNT_W=4, 20 hits) → hit_count stays at 0xF.

Source files
------------

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with an integrated miss/refill FSM.
// Sits between the fetch stage and instruction memory. A hit in IDLE returns the
// word with no added latency. A miss starts one whole-line refill over a req/ack
// handshake. A flush clears every valid bit. Saturating counters track hits and misses.
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   cpu_req, cpu_addr    fetch request and byte address (bits [1:0] ignored)
//   hit, cpu_instr       fetched word valid this cycle / the word itself
//   busy                 refill or flush in progress
//   mem_req, mem_addr    line refill request and line-aligned address
//   mem_ack, mem_line    refill data valid (completes the refill) / line data, word 0 in LSBs
//   flush                invalidate all lines
//   hit_count            saturating hit counter
//   miss_count           saturating miss counter
module icache_dm_refill #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned NUM_LINES      = 16,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             cpu_req,
  input  logic [ADDR_W-1:0]                cpu_addr,
  output logic                             hit,
  output logic [WORD_W-1:0]                cpu_instr,
  output logic                             busy,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_ack,
  input  logic [WORDS_PER_LINE*WORD_W-1:0] mem_line,
  input  logic                             flush,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 miss_count
);

  localparam int unsigned OFF   = $clog2(WORDS_PER_LINE) + 2;
  localparam int unsigned IDX   = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - OFF - IDX;

  typedef enum logic [1:0] {StIdle, StRefill, StFlush} state_e;

  state_e                                  state_q, state_d;
  logic [NUM_LINES-1:0]                    valid_q, valid_d;
  logic [ADDR_W-1:0]                       mem_addr_q, mem_addr_d;
  logic                                    flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]                        hit_count_q, hit_count_d;
  logic [CNT_W-1:0]                        miss_count_q, miss_count_d;

  // Storage arrays carry no reset; valid_q alone qualifies their contents.
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0]   data_mem [NUM_LINES];
  logic [TAG_W-1:0]                        tag_mem  [NUM_LINES];

  logic [OFF-1:0]                          byte_off;
  logic [OFF-3:0]                          word_sel;
  logic [IDX-1:0]                          cpu_idx;
  logic [TAG_W-1:0]                        cpu_tag;
  logic [IDX-1:0]                          fill_idx;
  logic [TAG_W-1:0]                        fill_tag;
  logic                                    lookup_hit;
  logic                                    fill_we;

  assign byte_off = cpu_addr[OFF-1:0];
  assign word_sel = (OFF-2)'(byte_off >> 2);
  assign cpu_idx  = cpu_addr[OFF+IDX-1:OFF];
  assign cpu_tag  = cpu_addr[ADDR_W-1:OFF+IDX];

  // The refill writes the line captured at miss time, not the live cpu_addr.
  assign fill_idx = mem_addr_q[OFF+IDX-1:OFF];
  assign fill_tag = mem_addr_q[ADDR_W-1:OFF+IDX];

  assign lookup_hit = (state_q == StIdle) && cpu_req && valid_q[cpu_idx] &&
                      (tag_mem[cpu_idx] == cpu_tag);

  assign hit       = lookup_hit;
  // Gated so that the unreset data array never reaches the output.
  assign cpu_instr = lookup_hit ? data_mem[cpu_idx][word_sel] : '0;
  assign busy      = (state_q != StIdle);
  assign mem_req   = (state_q == StRefill);
  assign mem_addr  = mem_addr_q;
  assign fill_we   = (state_q == StRefill) && mem_ack;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_addr_d   = mem_addr_q;
    flush_pend_d = flush_pend_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;

    if (lookup_hit && !(&hit_count_q)) begin
      hit_count_d = hit_count_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StFlush;
        end else if (cpu_req && !lookup_hit) begin
          state_d    = StRefill;
          mem_addr_d = {cpu_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
          if (!(&miss_count_q)) begin
            miss_count_d = miss_count_q + CNT_W'(1);
          end
        end
      end
      StRefill: begin
        if (flush) begin
          flush_pend_d = 1'b1;
        end
        if (mem_ack) begin
          // A flush seen at any point during the refill leaves the new line invalid.
          valid_d[fill_idx] = !(flush_pend_q || flush);
          state_d           = (flush_pend_q || flush) ? StFlush : StIdle;
          flush_pend_d      = 1'b0;
        end
      end
      StFlush: begin
        valid_d      = '0;
        flush_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_addr_q   <= mem_addr_d;
      flush_pend_q <= flush_pend_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we) begin
      data_mem[fill_idx] <= mem_line;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed testbench for icache_dm_refill (CNT_W=4 so saturation is reachable).
// Inputs change 1 time unit after a rising edge. Outputs are sampled before the next edge.
module tb_icache_dm_refill;

  localparam int unsigned CNT_W = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         hit;
  logic [31:0]  cpu_instr;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_line;
  logic         flush;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  int checks   = 0;
  int failures = 0;

  icache_dm_refill #(
    .ADDR_W(32), .WORD_W(32), .WORDS_PER_LINE(4), .NUM_LINES(16), .CNT_W(CNT_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .hit        (hit),
    .cpu_instr  (cpu_instr),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_line   (mem_line),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and return 1 unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  localparam logic [127:0] LineA = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
  localparam logic [127:0] LineE = {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000};
  localparam logic [127:0] LineF = {32'hF3F3_0003, 32'hF2F2_0002, 32'hF1F1_0001, 32'hF0F0_0000};
  localparam logic [127:0] LineG = {32'h6363_0003, 32'h6262_0002, 32'h6161_0001, 32'h6060_0000};
  localparam logic [127:0] LineH = {32'h7373_0003, 32'h7272_0002, 32'h7171_0001, 32'h7070_0000};

  // Ack the pending refill with the given line; return one unit after the ack edge.
  task automatic ack_line(input logic [127:0] line);
    mem_ack  = 1'b1;
    mem_line = line;
    tick();
    mem_ack  = 1'b0;
    mem_line = '0;
  endtask

  initial begin
    reset_n  = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    mem_ack  = 1'b0;
    mem_line = '0;
    flush    = 1'b0;
    #12;
    check("rst_hit",       {63'd0, hit},      64'd0);
    check("rst_mem_req",   {63'd0, mem_req},  64'd0);
    check("rst_mem_addr",  {32'd0, mem_addr}, 64'd0);
    check("rst_busy",      {63'd0, busy},     64'd0);
    check("rst_instr",     {32'd0, cpu_instr}, 64'd0);
    check("rst_hit_cnt",   {60'd0, hit_count},  64'd0);
    check("rst_miss_cnt",  {60'd0, miss_count}, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // First miss on 0x84, ack after 3 cycles in REFILL.
    cpu_req  = 1'b1;
    cpu_addr = 32'h84;
    #1 check("t1_cold_hit", {63'd0, hit}, 64'd0);
    tick();
    check("t1_mem_req",   {63'd0, mem_req},  64'd1);
    check("t1_mem_addr",  {32'd0, mem_addr}, 64'h80);
    check("t1_busy",      {63'd0, busy},     64'd1);
    check("t1_miss_cnt",  {60'd0, miss_count}, 64'd1);
    check("t1_refill_hit", {63'd0, hit}, 64'd0);
    tick();
    tick();
    check("t1_addr_held", {32'd0, mem_addr}, 64'h80);
    ack_line(LineA);
    check("t1_hit",    {63'd0, hit},       64'd1);
    check("t1_instr",  {32'd0, cpu_instr}, 64'hA1A1_0001);
    check("t1_busy_off", {63'd0, busy},    64'd0);
    tick();
    check("t1_hit_cnt", {60'd0, hit_count}, 64'd1);

    // Back-to-back hits on the same line.
    cpu_addr = 32'h80;
    #1 check("t2_hit0", {31'd0, hit, cpu_instr}, {31'd0, 1'b1, 32'hA0A0_0000});
    tick();
    cpu_addr = 32'h88;
    #1 check("t2_hit2", {31'd0, hit, cpu_instr}, {31'd0, 1'b1, 32'hA2A2_0002});
    tick();
    cpu_addr = 32'h8C;
    #1 check("t2_hit3", {31'd0, hit, cpu_instr}, {31'd0, 1'b1, 32'hA3A3_0003});
    tick();
    check("t2_hit_cnt", {60'd0, hit_count}, 64'd4);
    check("t2_no_req",  {63'd0, mem_req},   64'd0);

    // Index collision on line 0xA: tag 1 then tag 0 then tag 1 again.
    cpu_addr = 32'h1AC;
    tick();
    check("t3_addr_1a0", {32'd0, mem_addr}, 64'h1A0);
    check("t3_miss_cnt", {60'd0, miss_count}, 64'd2);
    ack_line(LineE);
    check("t3_e3", {31'd0, hit, cpu_instr}, {31'd0, 1'b1, 32'hE3E3_0003});
    tick();
    cpu_addr = 32'hAC;
    #1 check("t3_alias_miss", {63'd0, hit}, 64'd0);
    tick();
    check("t3_addr_0a0", {32'd0, mem_addr}, 64'hA0);
    check("t3_miss_cnt2", {60'd0, miss_count}, 64'd3);
    ack_line(LineF);
    check("t3_f3", {31'd0, hit, cpu_instr}, {31'd0, 1'b1, 32'hF3F3_0003});
    tick();
    cpu_addr = 32'h1AC;
    #1 check("t3_evicted", {63'd0, hit}, 64'd0);
    tick();
    check("t3_rereq", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h1A0});
    ack_line(LineE);
    tick();
    check("t3_hit_cnt", {60'd0, hit_count}, 64'd7);

    // Flush while a refill of 0x4 is pending.
    cpu_addr = 32'h4;
    tick();
    check("t4_miss_cnt", {60'd0, miss_count}, 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_still_req", {63'd0, mem_req}, 64'd1);
    ack_line(LineG);
    check("t4_flush_busy", {62'd0, busy, mem_req}, {62'd0, 1'b1, 1'b0});
    check("t4_flush_hit",  {63'd0, hit}, 64'd0);
    tick();
    check("t4_idle", {63'd0, busy}, 64'd0);
    cpu_addr = 32'h84;
    #1 check("t4_84_miss", {63'd0, hit}, 64'd0);
    tick();
    check("t4_84_req", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h80});
    check("t4_miss_cnt2", {60'd0, miss_count}, 64'd6);
    ack_line(LineH);
    check("t4_h1", {31'd0, hit, cpu_instr}, {31'd0, 1'b1, 32'h7171_0001});
    tick();
    cpu_addr = 32'h4;
    #1 check("t4_refilled_invalid", {63'd0, hit}, 64'd0);
    tick();
    check("t4_4_req", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h0});
    check("t4_miss_cnt3", {60'd0, miss_count}, 64'd7);
    check("t4_hit_cnt", {60'd0, hit_count}, 64'd8);

    // Reset in the middle of that refill.
    reset_n = 1'b0;
    #1;
    check("t5_req_drop",  {62'd0, mem_req, busy}, 64'd0);
    check("t5_cnts",      {56'd0, hit_count, miss_count}, 64'd0);
    check("t5_addr",      {32'd0, mem_addr}, 64'd0);
    tick();
    reset_n  = 1'b1;
    cpu_addr = 32'h84;
    #1 check("t5_84_miss", {63'd0, hit}, 64'd0);
    tick();
    check("t5_84_req", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h80});
    ack_line(LineH);

    // 20 consecutive hits saturate the 4-bit hit counter.
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    check("t6_sat_hit",  {60'd0, hit_count},  64'hF);
    check("t6_miss_cnt", {60'd0, miss_count}, 64'd1);
    check("t6_still_hit", {63'd0, hit}, 64'd1);
    cpu_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
